// File: rtl/abacus_seq_alu.sv
// abacus_seq_alu: sequential add / sub / shift-add multiply / restoring divide
// with a double-dabble BCD conversion of the result magnitude.
// Handshake: start (sampled in IDLE) -> busy through CALC, CONV, DONE -> done pulse.
// Optional build macro ABACUS_LEADZERO_BLANK_EN: leading zero BCD digits of
// bcd_out are replaced by 4'hF (display blank code); digit 0 is never blanked.
module abacus_seq_alu #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    result,
    output logic [WIDTH-1:0]      remainder,
    output logic                  neg,
    output logic                  div_zero,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

    state_t state_q, state_d;

    // Working registers
    logic [1:0]          op_q,   op_d;
    logic [WIDTH-1:0]    a_q,    a_d;     // multiplier (shifts right) / dividend->quotient (shifts left)
    logic [WIDTH-1:0]    b_q,    b_d;
    logic [PW-1:0]       acc_q,  acc_d;   // multiply accumulator
    logic [WIDTH-1:0]    rem_q,  rem_d;   // divide partial remainder
    logic [PW-1:0]       bin_q,  bin_d;   // final binary magnitude
    logic [PW-1:0]       sh_q,   sh_d;    // double-dabble binary shift register
    logic [4*DIGITS-1:0] bcd_q,  bcd_d;   // double-dabble BCD accumulator
    logic                neg_q,  neg_d;
    logic                dz_q,   dz_d;
    logic [CW-1:0]       cnt_q,  cnt_d;

    // Output registers, updated together at DONE entry
    logic [PW-1:0]       res_out_q, res_out_d;
    logic [WIDTH-1:0]    rem_out_q, rem_out_d;
    logic                neg_out_q, neg_out_d;
    logic                dz_out_q,  dz_out_d;
    logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;

    logic                calc_last;
    logic                conv_last;
    logic [WIDTH:0]      trial;
    logic [4*DIGITS-1:0] bcd_shift;
    logic [4*DIGITS-1:0] bcd_disp;

    // add/sub finish in one CALC edge; mul/div need one edge per operand bit
    assign calc_last = (op_q[1] == 1'b0) || (cnt_q == CW'(WIDTH - 1));
    assign conv_last = (cnt_q == CW'(PW - 1));

    // restoring-divide trial subtraction; bit WIDTH set means the trial went negative
    assign trial = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};

    // One double-dabble step: add 3 to digits >= 5, then shift left by one with the
    // next binary bit entering digit 0.
    always_comb begin
        logic [3:0] dig;
        logic       cin;
        cin       = sh_q[PW-1];
        bcd_shift = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (dig >= 4'd5) begin
                dig = dig + 4'd3;
            end
            bcd_shift[4*i +: 4] = {dig[2:0], cin};
            cin = dig[3];
        end
    end

`ifdef ABACUS_LEADZERO_BLANK_EN
    logic lead;
    // Blank zero digits from the top down until the first non-zero digit; digit 0 stays.
    always_comb begin
        bcd_disp = bcd_shift;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (bcd_shift[4*i +: 4] == 4'd0)) begin
                bcd_disp[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    // All digits shown, including leading zeros.
    always_comb begin
        bcd_disp = bcd_shift;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)     state_d = S_CALC;
            S_CALC: if (calc_last) state_d = S_CONV;
            S_CONV: if (conv_last) state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch operands, iterate arithmetic, iterate BCD, publish
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        bin_d     = bin_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        res_out_d = res_out_q;
        rem_out_d = rem_out_q;
        neg_out_d = neg_out_q;
        dz_out_d  = dz_out_q;
        bcd_out_d = bcd_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    rem_d = '0;
                    neg_d = 1'b0;
                    dz_d  = (op == OP_DIV) && (b == '0);
                    cnt_d = '0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                case (op_q)
                    OP_ADD: bin_d = PW'(a_q) + PW'(b_q);
                    OP_SUB: begin
                        if (a_q >= b_q) begin
                            bin_d = PW'(a_q - b_q);
                        end else begin
                            bin_d = PW'(b_q - a_q);
                            neg_d = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        // LSB-first multiplier bit selects the multiplicand shifted by the step count
                        if (a_q[0]) begin
                            acc_d = acc_q + (PW'(b_q) << cnt_q);
                        end
                        a_d   = a_q >> 1;
                        bin_d = acc_d;
                    end
                    default: begin
                        // MSB-first quotient bits replace the dividend bits as they shift out;
                        // b==0 naturally yields all-ones quotient and remainder == a
                        a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
                        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
                        bin_d = PW'(a_d);
                    end
                endcase
                if (calc_last) begin
                    cnt_d = '0;
                    sh_d  = bin_d;
                    bcd_d = '0;
                end
            end
            S_CONV: begin
                cnt_d = cnt_q + CW'(1);
                sh_d  = sh_q << 1;
                bcd_d = bcd_shift;
                if (conv_last) begin
                    cnt_d     = '0;
                    res_out_d = bin_q;
                    rem_out_d = (op_q == OP_DIV) ? rem_q : '0;
                    neg_out_d = neg_q;
                    dz_out_d  = dz_q;
                    bcd_out_d = bcd_disp;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            bin_q     <= '0;
            sh_q      <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            res_out_q <= '0;
            rem_out_q <= '0;
            neg_out_q <= 1'b0;
            dz_out_q  <= 1'b0;
            bcd_out_q <= '0;
        end else begin
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            bin_q     <= bin_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            res_out_q <= res_out_d;
            rem_out_q <= rem_out_d;
            neg_out_q <= neg_out_d;
            dz_out_q  <= dz_out_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = res_out_q;
    assign remainder = rem_out_q;
    assign neg       = neg_out_q;
    assign div_zero  = dz_out_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_abacus_seq_alu.sv
// Scoreboard bench for abacus_seq_alu: the stimulus process pushes reference-model
// results, a negedge monitor pops and compares whenever done is presented.
module tb_abacus_seq_alu;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, neg, div_zero;
    logic [PW-1:0] result;
    logic [W-1:0]  remainder;
    logic [4*D-1:0] bcd_out;

    abacus_seq_alu #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .remainder(remainder),
        .neg(neg), .div_zero(div_zero), .bcd_out(bcd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PW-1:0]  res;
        logic [W-1:0]   rem;
        logic           neg;
        logic           dz;
        logic [4*D-1:0] bcd;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    exp_t cur;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_hold();
        hold.res = '0; hold.rem = '0; hold.neg = 1'b0; hold.dz = 1'b0; hold.bcd = '0; hold.cyc = 0;
    endtask

    // Reference: plain arithmetic and decimal digit extraction
    function automatic exp_t model(input logic [1:0] o, input int unsigned x, input int unsigned y,
                                   input int acc_cyc);
        exp_t m;
        longint unsigned r, rm, t;
        bit n, dz;
        int nd;
        r = 0; rm = 0; n = 0; dz = 0;
        case (o)
            2'b00: r = x + y;
            2'b01: if (x >= y) r = x - y; else begin r = y - x; n = 1; end
            2'b10: r = longint'(x) * longint'(y);
            default: begin
                if (y == 0) begin r = (1 << W) - 1; rm = x; dz = 1; end
                else begin r = x / y; rm = x % y; end
            end
        endcase
        m.res = PW'(r);
        m.rem = W'(rm);
        m.neg = n;
        m.dz  = dz;
        m.bcd = '0;
        t = r;
        for (int i = 0; i < D; i++) begin
            m.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef ABACUS_LEADZERO_BLANK_EN
        nd = 1;
        t = r / 10;
        while (t != 0) begin nd++; t = t / 10; end
        for (int i = nd; i < D; i++) m.bcd[4*i +: 4] = 4'hF;
`else
        nd = 0;
`endif
        m.cyc = acc_cyc + (o[1] ? W : 1) + 2 * W;
        return m;
    endfunction

    // Monitor: compare on done, otherwise outputs must hold their last delivered values
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                cur = sb.pop_front();
                $display("txn done cycle=%0d result=%0d rem=%0d neg=%0b dz=%0b bcd=%05h",
                         cyc, result, remainder, neg, div_zero, bcd_out);
                chk("done_cycle", cyc, cur.cyc);
                chk("result", result, cur.res);
                chk("remainder", remainder, cur.rem);
                chk("neg", neg, cur.neg);
                chk("div_zero", div_zero, cur.dz);
                chk("bcd_out", bcd_out, cur.bcd);
                chk("busy_at_done", busy, 1);
                hold = cur;
            end
        end else begin
            chk("outputs_hold", {result, remainder, neg, div_zero, bcd_out},
                {hold.res, hold.rem, hold.neg, hold.dz, hold.bcd});
            if (sb.size() != 0) chk("busy_during_op", busy, 1);
        end
    end

    task automatic issue(input logic [1:0] o, input int unsigned x, input int unsigned y);
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: got busy=1 after %0d cycles, expected 0", w);
        end
        op = o; a = W'(x); b = W'(y); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        sb.push_back(model(o, x, y, cyc));
    endtask

    initial begin
        int w;
        clear_hold();
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_outputs", {result, remainder, neg, div_zero, bcd_out}, 0);
        @(negedge clk);
        clr_n = 1'b1;

        issue(2'b00, 200, 100);
        issue(2'b01, 5, 9);
        issue(2'b01, 9, 9);
        issue(2'b10, 255, 255);
        issue(2'b11, 200, 7);
        issue(2'b11, 13, 0);
        issue(2'b00, 3, 4);
        issue(2'b00, 0, 0);
        issue(2'b00, 255, 255);
        issue(2'b01, 0, 255);
        issue(2'b10, 0, 77);
        issue(2'b11, 255, 1);
        issue(2'b11, 0, 5);
        issue(2'b11, 5, 255);
        issue(2'b11, 0, 0);

        // start pulsed with new operands during CONV is ignored
        issue(2'b10, 123, 45);
        repeat (12) @(negedge clk);
        op = 2'b01; a = 8'd9; b = 8'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        repeat (150) begin
            logic [1:0] ro;
            int unsigned rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom_range(0, 255);
            ry = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            issue(ro, rx, ry);
        end

        // asynchronous reset mid-CALC aborts with no done pulse
        issue(2'b10, 200, 201);
        repeat (3) @(negedge clk);
        #2;
        clr_n = 1'b0;
        sb.delete();
        clear_hold();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_outputs", {result, remainder, neg, div_zero, bcd_out}, 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_abort", busy, 0);

        issue(2'b11, 100, 9);
        issue(2'b01, 17, 250);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d outstanding, expected 0", sb.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/abacus_seq_alu.md
Name: abacus_seq_alu

Overview:
- Parametrised, sequential successor of the board-level abacus datapath.
- Takes two WIDTH-bit unsigned operands and an opcode, then computes one of: add, subtract (magnitude plus sign), multiply (iterative shift-add) or divide (iterative restoring, quotient and remainder).
- Converts the result magnitude to packed BCD with a sequential double-dabble pass.
- Sits between the switch/button front end and the 7-segment scroll/display logic; the start/busy/done handshake replaces the free-running combinational arithmetic.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- DIGITS, 5, BCD digits of bcd_out; must hold (2^WIDTH-1)^2 in decimal.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  operand A (dividend / minuend).
- b  in  WIDTH  operand B (divisor / subtrahend).
- busy  out  1  high from the start-accept edge until done deasserts.
- done  out  1  one-cycle pulse; result outputs are valid.
- result  out  2*WIDTH  binary magnitude (quotient for div), zero-extended.
- remainder  out  WIDTH  div remainder; 0 for other ops.
- neg  out  1  sub only: a<b.
- div_zero  out  1  div with b==0.
- bcd_out  out  4*DIGITS  packed BCD of result, digit 0 in [3:0].

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE; all outputs and internal registers 0. Reset deasserts synchronously into IDLE.
- FSM states and transitions:
  - IDLE -> CALC on start. a, b and op are latched at that edge; busy rises.
  - CALC -> CONV after C edges: C=1 for add/sub, C=WIDTH for mul/div.
  - CONV -> DONE after 2*WIDTH edges.
  - DONE -> IDLE after 1 edge; done=1 only in DONE.
- busy=1 in CALC, CONV and DONE. With start sampled at edge E0, done is high in the cycle following edge E0+C+2*WIDTH. For WIDTH=8: add/sub 17, mul/div 24.
- start outside IDLE is ignored. No queueing; latched operands are unaffected.
- Output update: result, remainder, neg, div_zero and bcd_out update together at the DONE entry edge. They hold stable through IDLE until the next DONE; they are not cleared by a new start.
- add: result = a+b (WIDTH+1 significant bits). neg=0.
- sub: a>=b gives result=a-b, neg=0. a<b gives result=b-a, neg=1. a==b gives 0, neg=0.
- mul: shift-add, one multiplier bit per cycle, LSB first. result = a*b exact in 2*WIDTH bits.
- div: restoring, one quotient bit per cycle, MSB first. result = a/b, remainder = a%b.
- b==0 in div: result = {WIDTH zeros, WIDTH ones}, remainder = a, div_zero=1. Still takes C=WIDTH cycles and the full CONV.
- CONV: double dabble over the 2*WIDTH-bit result magnitude. Add-3 on digits >=5 before each shift; one shift per cycle. Upper digits beyond the magnitude are 0.
- Reset mid-operation (any state) aborts immediately; no done pulse follows.
- op values are all legal; there is no error state.

Optional Feature:
- ABACUS_LEADZERO_BLANK_EN defined: at the DONE entry edge, leading zero BCD digits of bcd_out are replaced by 4'hF (display blank code). Digit 0 is never blanked; result 0 shows a single 0.
- Undefined: bcd_out carries all digits, including leading zeros.
- Handshake, latency and the other outputs are identical either way.

Test Plan:
- WIDTH=8, op=00, a=200, b=100, start -> done 17 cycles after accept; result=300; bcd_out=20'h00300; neg=0.
- op=01, a=5, b=9 -> result=4, neg=1, bcd_out=20'h00004. Repeat with a=9, b=9 -> result=0, neg=0.
- op=10, a=255, b=255 -> done at 24 cycles; result=65025; bcd_out=20'h65025.
- op=11, a=200, b=7 -> result=28, remainder=4, div_zero=0. Then a=13, b=0 -> result=255, remainder=13, div_zero=1.
- start re-pulsed with new operands during CONV -> ignored; the first result is delivered and busy stays high continuously. clr_n low mid-CALC -> all outputs 0 at once, busy=0, no done pulse.
- With ABACUS_LEADZERO_BLANK_EN: add 3+4 -> bcd_out=20'hFFFF7. Add 0+0 -> bcd_out=20'hFFFF0.
